// File: rtl/dbus_mmio_if.sv
// Core data-port bus plus the TX byte stream port of dbus_mmio, bundled as one interface.
// tx stream: a byte moves exactly on a rising edge where tx_valid & tx_ready; tx_data holds until then.
interface dbus_mmio_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        irq;

  modport master (
    output MemWrite, ALUResult, WriteData, tx_ready,
    input  ReadData, tx_valid, tx_data, irq
  );

  modport slave (
    input  MemWrite, ALUResult, WriteData, tx_ready,
    output ReadData, tx_valid, tx_data, irq
  );
endinterface

// File: rtl/dbus_mmio.sv
// Data-side slave for the single-cycle core: word RAM, timer/compare page and a TX byte FIFO.
// Define DBUS_MMIO_TIMER_EN to build the timer; without it TIMER_CNT/CMP read 0 and irq is 0.
module dbus_mmio #(
  parameter int RAM_AW   = 6,
  parameter int TX_DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  dbus_mmio_if.slave bus
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);

  logic [31:0] ram_mem [2**RAM_AW];
  logic [7:0]  fifo_mem [TX_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic              sel_ram, sel_mmio;
  logic [1:0]        reg_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_status, push_req, push_ok, pop, full, empty;
  logic [31:0]       timer_cnt, timer_cmp;
  logic              match;
  logic [3:0]        cnt_field;
  logic [31:0]       rdata;
  logic              addr_lsb_unused;

  assign sel_ram   = (bus.ALUResult[31:28] == 4'h0);
  assign sel_mmio  = (bus.ALUResult[31:4] == 28'h8000000);
  assign reg_off   = bus.ALUResult[3:2];
  assign ram_idx   = bus.ALUResult[RAM_AW+1:2];
  assign addr_lsb_unused = ^bus.ALUResult[1:0];

  assign wr_status = bus.MemWrite && sel_mmio && (reg_off == 2'd2);
  assign push_req  = bus.MemWrite && sel_mmio && (reg_off == 2'd3);

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign pop       = !empty && bus.tx_ready;
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign push_ok   = push_req && (!full || pop);
  assign cnt_field = 4'(count_q);

`ifdef DBUS_MMIO_TIMER_EN
  logic [31:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic        match_q, match_d;
  logic        wr_cnt, wr_cmp;

  assign wr_cnt = bus.MemWrite && sel_mmio && (reg_off == 2'd0);
  assign wr_cmp = bus.MemWrite && sel_mmio && (reg_off == 2'd1);

  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    cmp_d   = cmp_q;
    match_d = match_q;
    if (wr_cnt) cnt_d = bus.WriteData;
    if (wr_cmp) cmp_d = bus.WriteData;
    if (wr_status && bus.WriteData[0]) match_d = 1'b0;
    // Set is evaluated last so it beats a same-cycle W1C.
    if (cnt_q == cmp_q) match_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 32'd0;
      cmp_q   <= 32'hFFFF_FFFF;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end

  assign timer_cnt = cnt_q;
  assign timer_cmp = cmp_q;
  assign match     = match_q;
`else
  assign timer_cnt = 32'd0;
  assign timer_cmp = 32'd0;
  assign match     = 1'b0;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (wr_status && bus.WriteData[3]) overflow_d = 1'b0;
    if (push_req && !push_ok)          overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage arrays carry no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= bus.WriteData[7:0];
    if (bus.MemWrite && sel_ram) ram_mem[ram_idx] <= bus.WriteData;
  end

  always_comb begin
    rdata = 32'd0;
    if (sel_ram) begin
      rdata = ram_mem[ram_idx];
    end else if (sel_mmio) begin
      case (reg_off)
        2'd0:    rdata = timer_cnt;
        2'd1:    rdata = timer_cmp;
        2'd2:    rdata = {24'd0, cnt_field, overflow_q, empty, full, match};
        default: rdata = 32'd0;
      endcase
    end
  end

  assign bus.ReadData = rdata;
  assign bus.tx_valid = !empty;
  assign bus.tx_data  = fifo_mem[rd_ptr_q];
  assign bus.irq      = match;
endmodule

// File: doc/dbus_mmio.md
# dbus_mmio

Data-side bus slave hanging off the single-cycle ARM core's data port (`MemWrite`, `ALUResult`, `WriteData`, `ReadData`). It decodes the core's data address into a word-addressed data RAM and a small MMIO page: a free-running timer with compare, and a byte TX FIFO drained through a valid/ready port. Reads are combinational so the core completes loads in its single cycle. Writes commit on the rising clock edge.

## Interface
Parameters:
- RAM_AW, 6: data RAM word-address width (2^RAM_AW words of 32 bits)
- TX_DEPTH, 4: TX FIFO depth in bytes; power of two, ≥2

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low; state cleared while 0
- MemWrite  in  1  store strobe from core
- ALUResult  in  32  byte address from core; bits[1:0] ignored
- WriteData  in  32  store data from core
- ReadData  out  32  load data to core, combinational
- tx_valid  out  1  FIFO non-empty
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  consumer accepts head when tx_valid & tx_ready
- irq  out  1  timer match sticky flag

## Operation
Address decode:
- RAM when ALUResult[31:28]==0x0; word index ALUResult[RAM_AW+1:2]; upper bits aliased
- MMIO when ALUResult[31:4]==0x8000000:
  - +0x0 TIMER_CNT RW: write loads value
  - +0x4 TIMER_CMP RW
  - +0x8 STATUS: bit0 match (W1C), bit1 fifo full, bit2 fifo empty, bit3 overflow (W1C), bits[7:4] fifo count; others read 0, ignored on write
  - +0xC TX_DATA WO: write pushes WriteData[7:0]; reads 0
- Anything else: reads 0x00000000, writes ignored.

Timer:
- TIMER_CNT increments by 1 each cycle and wraps 0xFFFFFFFF→0.
- A write loads the written value, with no increment that cycle.
- match sets whenever TIMER_CNT == TIMER_CMP, comparing registered values.
- If a set and a W1C clear occur in the same cycle, set wins.
- irq = match.

TX FIFO:
- Circular buffer with read/write pointers plus a count register.
- Push accepted if not full, or if a pop occurs in the same cycle.
- A rejected push drops the byte and sets overflow.
- Pop when tx_valid & tx_ready.
- tx_data is valid only while tx_valid=1; it must stay stable until popped.

RAM:
- Not reset; contents are undefined after power-up.
- A write then read of the same word returns the new data from the next cycle onward.

## Timing
- Reset values: TIMER_CNT=0, TIMER_CMP=0xFFFFFFFF, match=0, overflow=0, FIFO empty. Outputs tx_valid=0 and irq=0. ReadData follows the address combinationally, including during reset.
- Store latency: one edge. A load in the cycle after a store sees the stored value. A load in the same cycle as a store sees the old value.
- Reading TIMER_CNT returns the pre-increment value of that cycle.
- FIFO push to tx_valid: 1 cycle. Pop to next head byte: 1 cycle.
- Full: push+pop in the same cycle → count unchanged, no overflow.
- Empty: push only; a pop cannot occur.
- Pointers wrap modulo TX_DEPTH.
- Reset asserted mid-transfer discards FIFO contents immediately. tx_valid drops asynchronously.

## Configuration
- `DBUS_MMIO_TIMER_EN` defined: timer, TIMER_CNT/TIMER_CMP, STATUS.match and irq are implemented as above.
- Undefined: no timer logic. TIMER_CNT and TIMER_CMP read 0 and ignore writes. STATUS bit0=0 and irq tied to 0. RAM and FIFO behaviour are unchanged.

## Test plan
- Reset release, then read 0x80000008 → 0x00000004 (empty); tx_valid=0, irq=0.
- Store 0x12345678 to 0x00000010, then load 0x00000010 next cycle → 0x12345678. Load 0x00000013 → same word. Load 0x40000000 → 0.
- Write TIMER_CMP=5, TIMER_CNT=0 → match/irq rises 6 cycles after the CNT write edge. W1C 0x1 to STATUS clears it. Without the macro, irq stays 0 and reads return 0.
- With tx_ready=0, push 0xA1..0xA5 (TX_DEPTH=4) → STATUS=0x0000004A (count 4, full, overflow). tx_data=0xA1. The byte 0xA5 is lost.
- From full, push 0xB0 in the same cycle as tx_ready=1 → 0xA1 popped, 0xB0 accepted, count stays 4, overflow not newly set. Drain order is A2, A3, A4, B0.
- Drop reset mid-drain with the FIFO holding 3 bytes → tx_valid=0 immediately. STATUS reads 0x00000004 after release.
